fwd_hazard_unit: RTL and testbench

- Generates the 2-bit operand-select codes for the EX-stage 3-to-1 operand muxes (S=00 register file, 01 EX/MEM result, 10 MEM/WB result) and the load-use stall for the pipelined datapath.
- Shadows the destination/control fields of the in-flight instructions in its own EX/MEM/WB tracking registers.
- Selects are registered and valid in the same cycle the consuming instruction occupies EX.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/fwd_hazard_unit_if.sv | 30 +++
 rtl/fwd_hazard_unit_fwd_sel_calc.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 88 ++++++++
 tb/tb_fwd_hazard_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the forwarding/hazard unit: select codes,
// address width and the tracking-slot layout.
package pipe_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_SRC_SEL = 2;

  // Operand-mux select codes; 2'b11 is never produced.
  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  // Shadow of one in-flight instruction's destination/control fields.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request fields in, stall and operand selects out.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int NUM_SRC_SEL = pipe_pkg::NUM_SRC_SEL
);

  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic [REG_ADDR_W-1:0]  id_dst;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   flush;
  logic                   stall;
  logic [NUM_SRC_SEL-1:0] fwd_a;
  logic [NUM_SRC_SEL-1:0] fwd_b;

  // Pipeline control side: presents the ID instruction, consumes the results.
  modport master (
    output id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, flush,
    input  stall, fwd_a, fwd_b
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, flush,
    output stall, fwd_a, fwd_b
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel_calc.sv
// Priority compare of one source address against the EX and MEM
// tracking slots; the younger producer (EX) wins.
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_valid,
  input  logic                  ex_regwrite,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  output logic [1:0]            sel
);

  // Register 0 is never forwarded; WB matches are served by the register
  // file because it writes before it reads.
  always_comb begin
    sel = SEL_RF;
    if (src != '0) begin
      if (ex_valid && ex_regwrite && (ex_dst == src)) begin
        sel = SEL_EXMEM;
      end else if (mem_valid && mem_regwrite && (mem_dst == src)) begin
        sel = SEL_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the EX stage.
// Selects are computed as an instruction enters EX and registered, so
// they are valid for the whole cycle that instruction spends in EX.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int NUM_SRC_SEL = pipe_pkg::NUM_SRC_SEL  // must be 2
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
);

  import pipe_pkg::*;

  slot_t                  ex_reg, mem_reg, wb_reg;
  slot_t                  ex_next;
  logic [NUM_SRC_SEL-1:0] fwd_reg  [2];
  logic [NUM_SRC_SEL-1:0] fwd_next [2];
  logic [REG_ADDR_W-1:0]  src      [2];
  logic [1:0]             sel_calc [2];
  logic                   stall_hit;
  logic                   advance;
  logic                   wb_unused;

  assign src[0] = bus.id_rs;
  assign src[1] = bus.id_rt;

  // A load in EX whose (non-zero) destination is read by the ID instruction.
  assign stall_hit = bus.id_valid && ex_reg.valid && ex_reg.memread &&
                     (ex_reg.dst != '0) &&
                     ((ex_reg.dst == bus.id_rs) || (ex_reg.dst == bus.id_rt));

  // Flush wins over stall: both produce a bubble in EX.
  assign advance = bus.id_valid && !stall_hit && !bus.flush;

  // The WB slot is tracked for pipeline fidelity but never forwarded from.
  assign wb_unused = ^wb_reg;

  // Select the slot that enters EX: the ID instruction or a bubble.
  always_comb begin
    ex_next = SLOT_BUBBLE;
    if (advance) begin
      ex_next.valid    = 1'b1;
      ex_next.dst      = bus.id_dst;
      ex_next.regwrite = bus.id_regwrite;
      ex_next.memread  = bus.id_memread;
    end
  end

  // One priority compare per operand (A from rs, B from rt).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      fwd_sel_calc u_calc (
        .src          (src[gi]),
        .ex_valid     (ex_reg.valid),
        .ex_regwrite  (ex_reg.regwrite),
        .ex_dst       (ex_reg.dst),
        .mem_valid    (mem_reg.valid),
        .mem_regwrite (mem_reg.regwrite),
        .mem_dst      (mem_reg.dst),
        .sel          (sel_calc[gi])
      );
      assign fwd_next[gi] = advance ? sel_calc[gi] : SEL_RF;
    end
  endgenerate

  // Advance the tracking slots and latch the selects for the entering instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg     <= SLOT_BUBBLE;
      mem_reg    <= SLOT_BUBBLE;
      wb_reg     <= SLOT_BUBBLE;
      fwd_reg[0] <= SEL_RF;
      fwd_reg[1] <= SEL_RF;
    end else begin
      wb_reg     <= mem_reg;
      mem_reg    <= ex_reg;
      ex_reg     <= ex_next;
      fwd_reg[0] <= fwd_next[0];
      fwd_reg[1] <= fwd_next[1];
    end
  end

  assign bus.stall = stall_hit;
  assign bus.fwd_a = fwd_reg[0];
  assign bus.fwd_b = fwd_reg[1];

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios with fixed
// expectations plus a randomized run against an instruction-history model.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fwd_hazard_unit_if bus ();

  fwd_hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last three instructions that left ID, youngest first
  // (age 1 = now in EX, age 2 = in MEM, age 3 = in WB).
  typedef struct {
    bit v;
    int dst;
    bit rw;
    bit mr;
  } instr_t;

  instr_t hist [3];

  bit obs_stall, exp_stall;
  int obs_a, obs_b, exp_a, exp_b;

  // Youngest in-flight writer of src within two instructions; code equals its age.
  function automatic int model_sel(input int src);
    if (src == 0) return 0;
    for (int age = 1; age <= 2; age++) begin
      if (hist[age-1].v && hist[age-1].rw && hist[age-1].dst == src) return age;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
  endtask

  // One clock of stimulus; captures observed and modelled stall/selects.
  task automatic step(input bit r, input bit v, input int rs, input int rt,
                      input int dst, input bit rw, input bit mr, input bit fl);
    bit enter;
    @(negedge clk);
    rst             = r;
    bus.id_valid    = v;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_dst      = 5'(dst);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.flush       = fl;
    #1;
    obs_stall = bus.stall;
    exp_stall = v && hist[0].v && hist[0].mr && hist[0].dst != 0 &&
                (hist[0].dst == rs || hist[0].dst == rt);
    @(posedge clk);
    if (r) begin
      model_clear();
      exp_a = 0;
      exp_b = 0;
    end else begin
      enter = v && !exp_stall && !fl;
      exp_a = enter ? model_sel(rs) : 0;
      exp_b = enter ? model_sel(rt) : 0;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = enter ? '{1, dst, rw, mr} : '{0, 0, 0, 0};
    end
    #1;
    obs_a = int'(bus.fwd_a);
    obs_b = int'(bus.fwd_b);
    $display("txn t=%0t rst=%0d v=%0d rs=%0d rt=%0d dst=%0d rw=%0d mr=%0d fl=%0d -> stall=%0d fwd_a=%0d fwd_b=%0d",
             $time, r, v, rs, rt, dst, rw, mr, fl, obs_stall, obs_a, obs_b);
  endtask

  task automatic drain();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 8, 9, 8, 1, 1, 0);
      checks += 3;
      if (obs_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0d want 0", obs_stall); end
      if (obs_a !== 0) begin failures++; $display("FAIL reset_fwd_a: got %0d want 0", obs_a); end
      if (obs_b !== 0) begin failures++; $display("FAIL reset_fwd_b: got %0d want 0", obs_b); end
    end
    step(0, 1, 8, 9, 8, 1, 0, 0);
    checks += 3;
    if (obs_stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall: got %0d want 0", obs_stall); end
    if (obs_a !== 0) begin failures++; $display("FAIL post_reset_fwd_a: got %0d want 0", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL post_reset_fwd_b: got %0d want 0", obs_b); end
  endtask

  task automatic test_reset_mid();
    drain();
    step(0, 1, 1, 2, 8, 1, 0, 0);
    step(1, 1, 8, 8, 3, 1, 0, 0);
    checks += 1;
    if (obs_a !== 0) begin failures++; $display("FAIL mid_reset_fwd_a: got %0d want 0", obs_a); end
    step(0, 1, 8, 8, 3, 1, 0, 0);
    checks += 3;
    if (obs_stall !== 1'b0) begin failures++; $display("FAIL mid_reset_stall: got %0d want 0", obs_stall); end
    if (obs_a !== 0) begin failures++; $display("FAIL mid_reset_first_a: got %0d want 0", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL mid_reset_first_b: got %0d want 0", obs_b); end
  endtask

  task automatic test_exmem_fwd();
    drain();
    step(0, 1, 1, 2, 8, 1, 0, 0);
    step(0, 1, 8, 9, 3, 1, 0, 0);
    checks += 3;
    if (obs_stall !== 1'b0) begin failures++; $display("FAIL exmem_stall: got %0d want 0", obs_stall); end
    if (obs_a !== 1) begin failures++; $display("FAIL exmem_fwd_a: got %0d want 1", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL exmem_fwd_b: got %0d want 0", obs_b); end
  endtask

  task automatic test_priority();
    drain();
    step(0, 1, 1, 2, 8, 1, 0, 0);
    step(0, 1, 3, 4, 8, 1, 0, 0);
    step(0, 1, 12, 8, 6, 1, 0, 0);
    checks += 2;
    if (obs_a !== 0) begin failures++; $display("FAIL priority_fwd_a: got %0d want 0", obs_a); end
    if (obs_b !== 1) begin failures++; $display("FAIL priority_fwd_b: got %0d want 1", obs_b); end
  endtask

  task automatic test_memwb_fwd();
    drain();
    step(0, 1, 1, 2, 8, 1, 0, 0);
    step(0, 1, 1, 2, 5, 1, 0, 0);
    step(0, 1, 5, 8, 6, 1, 0, 0);
    checks += 2;
    if (obs_a !== 1) begin failures++; $display("FAIL memwb_fwd_a: got %0d want 1", obs_a); end
    if (obs_b !== 2) begin failures++; $display("FAIL memwb_fwd_b: got %0d want 2", obs_b); end
  endtask

  task automatic test_reg_zero();
    drain();
    step(0, 1, 1, 2, 0, 1, 0, 0);
    step(0, 1, 0, 0, 4, 1, 0, 0);
    checks += 2;
    if (obs_a !== 0) begin failures++; $display("FAIL zero_fwd_a: got %0d want 0", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL zero_fwd_b: got %0d want 0", obs_b); end
  endtask

  task automatic test_load_use();
    drain();
    step(0, 1, 1, 2, 10, 1, 1, 0);
    step(0, 1, 10, 3, 4, 1, 0, 0);
    checks += 3;
    if (obs_stall !== 1'b1) begin failures++; $display("FAIL loaduse_stall: got %0d want 1", obs_stall); end
    if (obs_a !== 0) begin failures++; $display("FAIL loaduse_bubble_a: got %0d want 0", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL loaduse_bubble_b: got %0d want 0", obs_b); end
    step(0, 1, 10, 3, 4, 1, 0, 0);
    checks += 3;
    if (obs_stall !== 1'b0) begin failures++; $display("FAIL loaduse_release: got %0d want 0", obs_stall); end
    if (obs_a !== 2) begin failures++; $display("FAIL loaduse_fwd_a: got %0d want 2", obs_a); end
    if (obs_b !== 0) begin failures++; $display("FAIL loaduse_fwd_b: got %0d want 0", obs_b); end
  endtask

  task automatic test_flush_vs_stall();
    drain();
    step(0, 1, 1, 2, 10, 1, 1, 0);
    step(0, 1, 10, 3, 4, 1, 0, 1);
    checks += 2;
    if (obs_stall !== 1'b1) begin failures++; $display("FAIL flush_stall_seen: got %0d want 1", obs_stall); end
    if (obs_a !== 0) begin failures++; $display("FAIL flush_bubble_a: got %0d want 0", obs_a); end
    step(0, 1, 10, 3, 4, 1, 0, 0);
    checks += 2;
    if (obs_stall !== 1'b0) begin failures++; $display("FAIL flush_next_stall: got %0d want 0", obs_stall); end
    if (obs_a !== 2) begin failures++; $display("FAIL flush_next_fwd_a: got %0d want 2", obs_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
      checks += 3;
      if (obs_stall !== exp_stall) begin failures++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, obs_stall, exp_stall); end
      if (obs_a !== exp_a) begin failures++; $display("FAIL rand_fwd_a[%0d]: got %0d want %0d", i, obs_a, exp_a); end
      if (obs_b !== exp_b) begin failures++; $display("FAIL rand_fwd_b[%0d]: got %0d want %0d", i, obs_b, exp_b); end
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.id_valid    = 1'b0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_dst      = '0;
    bus.id_regwrite = 1'b0;
    bus.id_memread  = 1'b0;
    bus.flush       = 1'b0;
    model_clear();
    test_reset();
    test_exmem_fwd();
    test_priority();
    test_memwb_fwd();
    test_reg_zero();
    test_load_use();
    test_flush_vs_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
